// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC frame scheduler: FSM encoding,
// channel-select values and the fixed control bits of the 16-bit DAC word.
package dac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_SEND_A = 3'd2,
        ST_LOAD_B = 3'd3,
        ST_SEND_B = 3'd4,
        ST_UPDATE = 3'd5
    } dac_state_t;

    localparam logic       CH_A      = 1'b0;
    localparam logic       CH_B      = 1'b1;
    localparam logic [2:0] CTRL_BITS = 3'b000;

    localparam int DEF_FRAME_CYCLES = 32;
    localparam int DEF_SAMPLE_DIV   = 100;
    localparam int DEF_DATA_W       = 12;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: counts 0..SAMPLE_DIV-1 while enabled and flags the
// last count as the sample tick. Disabling parks the count at zero.
module sample_tick_gen
    import dac_pkg::*;
#(
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV
) (
    input  logic clk,
    input  logic RST,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (RST || !enable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = enable && (cnt == CNT_LAST);

endmodule

// File: rtl/dac_frame_scheduler.sv
// Per sample tick: fetch channel A then B, present each as a 16-bit word with
// a one-cycle LD_pdata strobe, then request one DAC update via ldac_pulse.
module dac_frame_scheduler
    import dac_pkg::*;
#(
    parameter int SAMPLE_DIV   = DEF_SAMPLE_DIV,
    parameter int FRAME_CYCLES = DEF_FRAME_CYCLES,
    parameter int DATA_W       = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              enable,
    input  logic              clear_flags,
    input  logic [DATA_W-1:0] ch_a_data,
    input  logic              ch_a_valid,
    output logic              ch_a_ready,
    input  logic [DATA_W-1:0] ch_b_data,
    input  logic              ch_b_valid,
    output logic              ch_b_ready,
    output logic [15:0]       pdata,
    output logic              LD_pdata,
    output logic              ldac_pulse,
    output logic              busy,
    output logic              overrun,
    output logic              underrun
);

    localparam int FC_W = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_CYCLES - 1);

    dac_state_t        state;
    dac_state_t        state_next;
    logic [FC_W-1:0]   frame_cnt;
    logic [DATA_W-1:0] hold_a;
    logic [DATA_W-1:0] hold_b;
    logic              tick;
    logic              in_send;
    logic              overrun_set;
    logic              underrun_set;

    sample_tick_gen #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_tick (
        .clk   (clk),
        .RST   (RST),
        .enable(enable),
        .tick  (tick)
    );

    assign in_send = (state == ST_SEND_A) || (state == ST_SEND_B);

    always_ff @(posedge clk) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (tick) state_next = ST_LOAD_A;
            ST_LOAD_A: state_next = ST_SEND_A;
            ST_SEND_A: if (frame_cnt == FC_LAST) state_next = ST_LOAD_B;
            ST_LOAD_B: state_next = ST_SEND_B;
            ST_SEND_B: if (frame_cnt == FC_LAST) state_next = ST_UPDATE;
            ST_UPDATE: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Handshake: ready is a pure function of state (high for exactly the one
    // LOAD cycle of its channel) and never waits on valid; a sample transfers
    // only when ready and valid are both high. A missing sample replays the
    // held value and raises underrun.
    always_comb begin
        ch_a_ready = (state == ST_LOAD_A);
        ch_b_ready = (state == ST_LOAD_B);
        LD_pdata   = in_send && (frame_cnt == '0);
        ldac_pulse = (state == ST_UPDATE);
        busy       = (state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            frame_cnt <= '0;
        end else if (in_send && frame_cnt != FC_LAST) begin
            frame_cnt <= frame_cnt + 1'b1;
        end else begin
            frame_cnt <= '0;
        end
    end

    // pdata is loaded on the LOAD->SEND edge so it changes exactly with LD_pdata.
    always_ff @(posedge clk) begin
        if (RST) begin
            hold_a <= '0;
            hold_b <= '0;
            pdata  <= '0;
        end else if (state == ST_LOAD_A) begin
            if (ch_a_valid) begin
                hold_a <= ch_a_data;
                pdata  <= {CH_A, CTRL_BITS, ch_a_data};
            end else begin
                pdata  <= {CH_A, CTRL_BITS, hold_a};
            end
        end else if (state == ST_LOAD_B) begin
            if (ch_b_valid) begin
                hold_b <= ch_b_data;
                pdata  <= {CH_B, CTRL_BITS, ch_b_data};
            end else begin
                pdata  <= {CH_B, CTRL_BITS, hold_b};
            end
        end
    end

    assign overrun_set  = tick && (state != ST_IDLE);
    assign underrun_set = ((state == ST_LOAD_A) && !ch_a_valid) ||
                          ((state == ST_LOAD_B) && !ch_b_valid);

    // A set event in the same cycle as clear_flags takes priority.
    always_ff @(posedge clk) begin
        if (RST) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (clear_flags) begin
                overrun <= 1'b0;
            end
            if (underrun_set) begin
                underrun <= 1'b1;
            end else if (clear_flags) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Bench for dac_frame_scheduler: a SAMPLE_DIV=100 instance driven through
// directed scenarios plus a SAMPLE_DIV=60 instance that provokes overrun.
module tb_dac_frame_scheduler;

    localparam int F = 32;
    localparam int W = 50;  // {cycle[31:0], kind[1:0], data[15:0]}

    // event kinds
    localparam logic [1:0] K_LD    = 2'd0;
    localparam logic [1:0] K_LDAC  = 2'd1;
    localparam logic [1:0] K_RDY_A = 2'd2;
    localparam logic [1:0] K_RDY_B = 2'd3;

    logic clk;
    int   errors = 0;
    int   checks = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp2_q[$];

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT 1 (SAMPLE_DIV=100) ----------------
    logic        RST, enable, clear_flags, ch_a_valid, ch_b_valid;
    logic [11:0] ch_a_data, ch_b_data;
    logic        ch_a_ready, ch_b_ready, LD_pdata, ldac_pulse, busy, overrun, underrun;
    logic [15:0] pdata;
    logic [31:0] cyc;
    logic        rst_q;
    logic [15:0] prev_pdata;

    dac_frame_scheduler #(.SAMPLE_DIV(100), .FRAME_CYCLES(F), .DATA_W(12)) dut (
        .clk(clk), .RST(RST), .enable(enable), .clear_flags(clear_flags),
        .ch_a_data(ch_a_data), .ch_a_valid(ch_a_valid), .ch_a_ready(ch_a_ready),
        .ch_b_data(ch_b_data), .ch_b_valid(ch_b_valid), .ch_b_ready(ch_b_ready),
        .pdata(pdata), .LD_pdata(LD_pdata), .ldac_pulse(ldac_pulse),
        .busy(busy), .overrun(overrun), .underrun(underrun)
    );

    // ---------------- DUT 2 (SAMPLE_DIV=60, illegal on purpose) ----------------
    logic        rst2, enable2, clear2, a_valid2, b_valid2;
    logic [11:0] a_data2, b_data2;
    logic        a_ready2, b_ready2, ld2, ldac2, busy2, overrun2, underrun2;
    logic [15:0] pdata2;
    logic [31:0] cyc2;
    logic        rst_q2;
    logic [15:0] prev_pdata2;
    logic        done2 = 1'b0;

    dac_frame_scheduler #(.SAMPLE_DIV(60), .FRAME_CYCLES(F), .DATA_W(12)) dut2 (
        .clk(clk), .RST(rst2), .enable(enable2), .clear_flags(clear2),
        .ch_a_data(a_data2), .ch_a_valid(a_valid2), .ch_a_ready(a_ready2),
        .ch_b_data(b_data2), .ch_b_valid(b_valid2), .ch_b_ready(b_ready2),
        .pdata(pdata2), .LD_pdata(ld2), .ldac_pulse(ldac2),
        .busy(busy2), .overrun(overrun2), .underrun(underrun2)
    );

    // cycle counters are zeroed by each DUT's reset: cycle N == divider count N
    always @(posedge clk) begin
        cyc    <= RST  ? 32'd0 : cyc + 32'd1;
        rst_q  <= RST;
        cyc2   <= rst2 ? 32'd0 : cyc2 + 32'd1;
        rst_q2 <= rst2;
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_ev(input int which, input int c, input logic [1:0] k, input logic [15:0] d);
        logic [W-1:0] e;
        e = {c[31:0], k, d};
        if (which == 0) exp_q.push_back(e);
        else            exp2_q.push_back(e);
    endtask

    // expected events of one complete frame whose tick is at cycle t
    task automatic push_frame(input int which, input int t, input logic [15:0] aw, input logic [15:0] bw);
        push_ev(which, t + 1,         K_RDY_A, 16'h0);
        push_ev(which, t + 2,         K_LD,    aw);
        push_ev(which, t + 2 + F,     K_RDY_B, 16'h0);
        push_ev(which, t + 3 + F,     K_LD,    bw);
        push_ev(which, t + 3 + 2 * F, K_LDAC,  16'h0);
    endtask

    task automatic pop_cmp(input int which, input logic [W-1:0] act, input string nm);
        logic [W-1:0] e;
        bit           have;
        have = 1'b0;
        e    = '0;
        if (which == 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            have = 1'b1;
        end else if (which == 1 && exp2_q.size() > 0) begin
            e = exp2_q.pop_front();
            have = 1'b1;
        end
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL %s: unexpected event cycle=%0d kind=%0d data=%h, none required",
                     nm, act[49:18], act[17:16], act[15:0]);
        end else if (act !== e) begin
            errors++;
            $display("FAIL %s: got cycle=%0d kind=%0d data=%h, required cycle=%0d kind=%0d data=%h",
                     nm, act[49:18], act[17:16], act[15:0], e[49:18], e[17:16], e[15:0]);
        end
    endtask

    task automatic wait_cyc(input int which, input int n);
        int i;
        i = 0;
        while (((which == 0) ? cyc : cyc2) != n[31:0] && i < 5000) begin
            @(negedge clk);
            i++;
        end
        if (((which == 0) ? cyc : cyc2) != n[31:0]) begin
            checks++;
            errors++;
            $display("FAIL wait_cyc%0d: cycle %0d not reached within budget", which, n);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (rst_q) begin
            chk("dut1_reset_ctrl", {25'd0, ch_a_ready, ch_b_ready, LD_pdata, ldac_pulse,
                                   busy, overrun, underrun}, 32'd0);
            chk("dut1_reset_pdata", {16'd0, pdata}, 32'd0);
        end else begin
            if (!LD_pdata) chk("dut1_pdata_stable", {16'd0, pdata}, {16'd0, prev_pdata});
            if (ch_a_ready) pop_cmp(0, {cyc, K_RDY_A, 16'h0}, "dut1_event");
            if (ch_b_ready) pop_cmp(0, {cyc, K_RDY_B, 16'h0}, "dut1_event");
            if (LD_pdata)   pop_cmp(0, {cyc, K_LD, pdata}, "dut1_event");
            if (ldac_pulse) pop_cmp(0, {cyc, K_LDAC, 16'h0}, "dut1_event");
        end
        prev_pdata <= pdata;
    end

    always @(negedge clk) begin
        if (rst_q2) begin
            chk("dut2_reset_ctrl", {25'd0, a_ready2, b_ready2, ld2, ldac2,
                                   busy2, overrun2, underrun2}, 32'd0);
        end else begin
            if (!ld2) chk("dut2_pdata_stable", {16'd0, pdata2}, {16'd0, prev_pdata2});
            if (a_ready2) pop_cmp(1, {cyc2, K_RDY_A, 16'h0}, "dut2_event");
            if (b_ready2) pop_cmp(1, {cyc2, K_RDY_B, 16'h0}, "dut2_event");
            if (ld2)      pop_cmp(1, {cyc2, K_LD, pdata2}, "dut2_event");
            if (ldac2)    pop_cmp(1, {cyc2, K_LDAC, 16'h0}, "dut2_event");
        end
        prev_pdata2 <= pdata2;
    end

    // ---------------- DUT 1 driver ----------------
    task automatic reset_dut();
        @(negedge clk);
        chk("dut1_queue_drained", exp_q.size(), 32'd0);
        RST = 1'b1;
        @(negedge clk);
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1; enable = 1'b1; clear_flags = 1'b0;
        ch_a_data = 12'h123; ch_a_valid = 1'b1;
        ch_b_data = 12'hABC; ch_b_valid = 1'b1;

        // Scenario 1: steady operation, B underrun in period 2, flag clearing
        reset_dut();
        push_frame(0, 99,  16'h0123, 16'h8ABC);
        push_frame(0, 199, 16'h0123, 16'h8ABC);
        push_frame(0, 299, 16'h0456, 16'h8ABC);
        wait_cyc(0, 150); chk("busy_in_frame", {31'd0, busy}, 32'd1);
        wait_cyc(0, 170); chk("busy_after_frame", {31'd0, busy}, 32'd0);
        wait_cyc(0, 200); ch_b_valid = 1'b0; ch_b_data = 12'h777;
        wait_cyc(0, 233); chk("underrun_before", {31'd0, underrun}, 32'd0);
        wait_cyc(0, 234); chk("underrun_set", {31'd0, underrun}, 32'd1);
        wait_cyc(0, 240); chk("underrun_sticky", {31'd0, underrun}, 32'd1);
        clear_flags = 1'b1;
        wait_cyc(0, 241); clear_flags = 1'b0;
        chk("underrun_cleared", {31'd0, underrun}, 32'd0);
        wait_cyc(0, 250); ch_a_data = 12'h456;
        wait_cyc(0, 333); chk("underrun_pre_tie", {31'd0, underrun}, 32'd0);
        clear_flags = 1'b1;
        wait_cyc(0, 334); clear_flags = 1'b0;
        chk("underrun_set_wins", {31'd0, underrun}, 32'd1);
        ch_b_valid = 1'b1; ch_b_data = 12'h321;
        wait_cyc(0, 370); chk("overrun_legal_div", {31'd0, overrun}, 32'd0);

        // Scenario 2: reset inside SEND_A aborts the frame
        ch_a_data = 12'h123; ch_b_data = 12'hABC;
        reset_dut();
        push_ev(0, 100, K_RDY_A, 16'h0);
        push_ev(0, 101, K_LD, 16'h0123);
        wait_cyc(0, 120);
        chk("pre_abort_pdata", {16'd0, pdata}, 32'h0123);
        chk("pre_abort_busy", {31'd0, busy}, 32'd1);
        reset_dut();
        push_frame(0, 99, 16'h0123, 16'h8ABC);
        wait_cyc(0, 98); chk("no_early_tick", {31'd0, busy}, 32'd0);
        wait_cyc(0, 170);

        // Scenario 3: enable dropped mid-frame, frame completes, no more ticks
        reset_dut();
        push_frame(0, 99,  16'h0123, 16'h8ABC);
        push_frame(0, 399, 16'h0123, 16'h8ABC);
        wait_cyc(0, 110); enable = 1'b0;
        wait_cyc(0, 150); chk("frame_runs_disabled", {31'd0, busy}, 32'd1);
        wait_cyc(0, 250); chk("idle_while_disabled", {31'd0, busy}, 32'd0);
        wait_cyc(0, 300); enable = 1'b1;
        wait_cyc(0, 470);
        chk("dut1_final_drained", exp_q.size(), 32'd0);

        for (int i = 0; i < 2000 && !done2; i++) @(negedge clk);
        if (!done2) begin
            checks++;
            errors++;
            $display("FAIL dut2_done: second instance sequence did not finish");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- DUT 2 driver ----------------
    initial begin
        rst2 = 1'b1; enable2 = 1'b1; clear2 = 1'b0;
        a_data2 = 12'h5A5; a_valid2 = 1'b1;
        b_data2 = 12'h0F0; b_valid2 = 1'b1;
        push_frame(1, 59,  16'h05A5, 16'h80F0);
        push_frame(1, 179, 16'h05A5, 16'h80F0);
        repeat (3) @(negedge clk);
        rst2 = 1'b0;
        wait_cyc(1, 119);
        chk("dut2_overrun_before", {31'd0, overrun2}, 32'd0);
        chk("dut2_busy_at_tick", {31'd0, busy2}, 32'd1);
        wait_cyc(1, 120); chk("dut2_overrun_set", {31'd0, overrun2}, 32'd1);
        wait_cyc(1, 250); enable2 = 1'b0;
        chk("dut2_overrun_sticky", {31'd0, overrun2}, 32'd1);
        chk("dut2_underrun", {31'd0, underrun2}, 32'd0);
        wait_cyc(1, 260);
        chk("dut2_queue_drained", exp2_q.size(), 32'd0);
        chk("dut2_idle", {31'd0, busy2}, 32'd0);
        clear2 = 1'b1;
        wait_cyc(1, 261); clear2 = 1'b0;
        chk("dut2_overrun_cleared", {31'd0, overrun2}, 32'd0);
        done2 = 1'b1;
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dac_frame_scheduler.md
Name: dac_frame_scheduler

Overview:
- Sequences the DAC transmission interface for the sine-wave path.
- Holds a sample-rate divider and, on each sample tick, takes one 12-bit sample from each of two channel generators (A, then B).
- Presents each sample as a 16-bit word to the interface with a one-cycle LD_pdata strobe, then issues one DAC update (LDAC) pulse once both frames are sent.
- Sits between the sine generators and Transmission_interface; it is the sole driver of LD_pdata.

Parameters:
- SAMPLE_DIV, 100, clocks per sample period; legal only when SAMPLE_DIV >= 2*FRAME_CYCLES+4.
- FRAME_CYCLES, 32, clocks the interface needs to shift one word after LD_pdata.
- DATA_W, 12, sample width.

Ports:
- clk  in  1  system clock, 100 MHz
- RST  in  1  synchronous, active-high reset
- enable  in  1  run/stop; low holds the divider at 0 and suppresses ticks
- clear_flags  in  1  one-cycle pulse; clears the sticky flags
- ch_a_data  in  DATA_W  channel A sample
- ch_a_valid  in  1  channel A sample available
- ch_a_ready  out  1  channel A sample consumed this cycle
- ch_b_data  in  DATA_W  channel B sample
- ch_b_valid  in  1  channel B sample available
- ch_b_ready  out  1  channel B sample consumed this cycle
- pdata  out  16  word to the interface: {ch_sel, 3'b000, sample}
- LD_pdata  out  1  one-cycle load strobe to the interface
- ldac_pulse  out  1  one-cycle DAC update request
- busy  out  1  high outside IDLE
- overrun  out  1  sticky: a tick arrived while not IDLE
- underrun  out  1  sticky: a channel was not valid in its slot

Behaviour:
- Reset (RST sampled high at a clk edge): state IDLE, divider 0, frame counter 0, hold_a = hold_b = 0. All outputs 0, including pdata and both flags. RST mid-frame aborts the frame immediately; no LD_pdata or ldac_pulse follows.
- Divider: counts 0..SAMPLE_DIV-1 while enable=1, then wraps to 0. Tick = counter at SAMPLE_DIV-1. enable=0 holds the counter at 0; a frame already in progress still completes.
- FSM states and transitions:
  - IDLE: on tick -> LOAD_A.
  - LOAD_A: one cycle; ch_a_ready=1. If ch_a_valid=1, hold_a <= ch_a_data; else hold_a keeps its value and underrun is set. -> SEND_A.
  - SEND_A: FRAME_CYCLES cycles. pdata = {1'b0,3'b000,hold_a}, registered and stable for the whole state. LD_pdata=1 on the first cycle only. -> LOAD_B.
  - LOAD_B, SEND_B: as LOAD_A and SEND_A, using ch_b_*, hold_b, ch_sel=1. -> UPDATE.
  - UPDATE: one cycle; ldac_pulse=1. -> IDLE.
- Timing, with the tick at cycle T:
  - ch_a_ready at T+1; LD_pdata (A) at T+2.
  - ch_b_ready at T+2+F; LD_pdata (B) at T+3+F.
  - ldac_pulse at T+3+2F.
  - IDLE again at T+4+2F, where F = FRAME_CYCLES.
- ready signals are asserted only in LOAD states, regardless of valid. A handshake occurs only when ready and valid are both high.
- Tick while not IDLE: tick dropped, overrun <= 1, current frame unaffected. This is only reachable with an illegal SAMPLE_DIV.
- Flags: sticky until clear_flags or RST. clear_flags in the same cycle as a set event: the set wins.
- pdata retains its last word in IDLE.
- busy = (state != IDLE).

Decomposition:
- Shared package dac_pkg holds:
  - FSM state encoding (IDLE, LOAD_A, SEND_A, LOAD_B, SEND_B, UPDATE);
  - CH_A = 1'b0, CH_B = 1'b1;
  - the control-bit constant 3'b000;
  - default FRAME_CYCLES = 32.
- One natural sub-module: sample_tick_gen (divider + enable, outputs the tick). FSM and datapath stay in the top.

Test Plan (F=32, SAMPLE_DIV=100):
- Reset, enable=1, A=12'h123 and B=12'hABC both valid -> first tick at cycle 99. ch_a_ready at 100. LD_pdata at 101 with pdata=16'h0123. LD_pdata at 134 with pdata=16'h8ABC. ldac_pulse at 166. Pattern repeats every 100 cycles.
- ch_b_valid=0 in the second period -> LD_pdata (B) resends 16'h8ABC, underrun=1. clear_flags -> underrun=0 next cycle.
- RST pulsed at cycle 120 (inside SEND_A) -> all outputs 0 next cycle. No LD_pdata at 134, no ldac_pulse. Next tick 100 cycles after RST release.
- enable dropped at cycle 110 -> the current frame completes (ldac_pulse at 166); no further ticks while low. Re-enable -> tick SAMPLE_DIV-1 cycles later.
- Instance with SAMPLE_DIV=60 -> second tick lands in SEND_B, overrun=1, frame order and ldac_pulse timing unchanged.
- Every sample period -> exactly 2 LD_pdata pulses, each one cycle wide, and 1 ldac_pulse. pdata stable across each SEND state.
